// File: rtl/addsub_arbiter_pkg.sv
// Shared constants, FSM encoding and grant selection for the add/sub arbiter.
package addsub_arbiter_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int NREQ      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // A lone requester always wins; on contention the round-robin holder wins.
    function automatic logic pick_grant(input logic [NREQ-1:0] valid, input logic rr);
        return (valid == 2'b11) ? rr : valid[1];
    endfunction
endpackage

// File: rtl/N_bit_adder.sv
// Ripple-carry add/subtract unit: B is inverted by cy_in, so cy_in=1 gives A-B.
module N_bit_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cy_in,
    output logic [N-1:0] answer,
    output logic         carry_out,
    output logic         overflow
);
    logic [N-1:0] b_eff;

    assign b_eff = b ^ {N{cy_in}};

    always_comb begin
        logic carry;
        carry  = cy_in;
        answer = '0;
        for (int i = 0; i < N; i++) begin
            answer[i] = a[i] ^ b_eff[i] ^ carry;
            carry     = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
        end
        carry_out = carry;
    end

    // Signed overflow: operands agree in sign but the result does not.
    assign overflow = (a[N-1] == b_eff[N-1]) && (answer[N-1] != a[N-1]);
endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin shares one add/sub unit between two requesters: accept, execute, respond.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_sub,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]      resp_sum,
    output logic                  resp_cout,
    output logic                  resp_ovf
);
    state_t             state;
    logic               rr;
    logic               grant;
    logic               gsel;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_sub;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic               add_ovf;

    assign gsel = pick_grant(req_valid, rr);

    N_bit_adder #(.N(WIDTH)) u_adder (
        .a         (op_a),
        .b         (op_b),
        .cy_in     (op_sub),
        .answer    (add_sum),
        .carry_out (add_cout),
        .overflow  (add_ovf)
    );

    // The only combinational output path: req_valid -> req_ready while idle.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && |req_valid)
            req_ready[gsel] = 1'b1;
    end

    always_comb begin
        resp_valid = '0;
        if (state == RESP)
            resp_valid[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= 1'b0;
            grant     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_sub    <= 1'b0;
            resp_sum  <= '0;
            resp_cout <= 1'b0;
            resp_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    grant  <= gsel;
                    op_a   <= gsel ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
                    op_b   <= gsel ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
                    op_sub <= req_sub[gsel];
                    state  <= EXEC;
                end
                EXEC: begin
                    resp_sum  <= add_sum;
                    resp_cout <= add_cout;
                    resp_ovf  <= add_ovf;
                    state     <= RESP;
                end
                RESP: if (resp_ready[grant]) begin
                    // Priority passes to the other requester only once a response completes.
                    rr    <= ~grant;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: vector table plus arbitration, backpressure and reset sequences.
module tb_addsub_arbiter;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [1:0]    req_sub;
    logic [1:0]    resp_valid;
    logic [1:0]    resp_ready;
    logic [W-1:0]  resp_sum;
    logic          resp_cout;
    logic          resp_ovf;

    int checks = 0;
    int errors = 0;

    addsub_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ovf   (resp_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        idx;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        rst_n      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Issue one op from requester idx and check accept, latency and result.
    task automatic run_op(input vec_t v);
        logic [1:0] onehot;
        bit         seen;
        onehot = v.idx ? 2'b10 : 2'b01;
        req_valid[v.idx] = 1'b1;
        req_sub[v.idx]   = v.sub;
        if (v.idx) begin
            req_a[W +: W] = v.a;
            req_b[W +: W] = v.b;
        end else begin
            req_a[0 +: W] = v.a;
            req_b[0 +: W] = v.b;
        end
        resp_ready = 2'b11;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) seen = 1'b1;
            else tick();
        end
        chk("accept", {62'd0, req_ready}, {62'd0, onehot});
        tick();
        req_valid[v.idx] = 1'b0;
        @(negedge clk);
        chk("exec_no_resp", {62'd0, resp_valid}, 64'd0);
        tick();
        @(negedge clk);
        chk("resp_valid", {62'd0, resp_valid}, {62'd0, onehot});
        chk("sum", {32'd0, resp_sum}, {32'd0, v.sum});
        chk("cout", {63'd0, resp_cout}, {63'd0, v.cout});
        chk("ovf", {63'd0, resp_ovf}, {63'd0, v.ovf});
        tick();
        @(negedge clk);
        chk("resp_done", {62'd0, resp_valid}, 64'd0);
        tick();
    endtask

    initial begin
        logic [1:0]  exp_rdy;
        logic [1:0]  exp_rv;
        logic [31:0] held;

        vecs[0] = '{1'b0, 32'd1011, 32'd1027, 1'b0, 32'd2038, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'd1011, 32'd1027, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'd5, 32'd5, 1'b1, 32'h0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1};

        req_a   = '0;
        req_b   = '0;
        req_sub = 2'b00;
        do_reset();
        @(negedge clk);
        chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_resp_valid", {62'd0, resp_valid}, 64'd0);
        chk("rst_sum", {32'd0, resp_sum}, 64'd0);
        chk("rst_cout_ovf", {62'd0, resp_cout, resp_ovf}, 64'd0);
        tick();

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Both requesters valid from reset release: grants alternate every 3 cycles.
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        rst_n      = 1'b0;
        req_a = {32'd10, 32'd10};
        req_b = {32'd3, 32'd3};
        req_sub = 2'b10;
        req_valid = 2'b11;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp_rdy = 2'b00;
            exp_rv  = 2'b00;
            if (c % 3 == 0) exp_rdy = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
            if (c % 3 == 2) exp_rv  = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("rr_ready_c%0d", c), {62'd0, req_ready}, {62'd0, exp_rdy});
            chk($sformatf("rr_rvalid_c%0d", c), {62'd0, resp_valid}, {62'd0, exp_rv});
            if (c % 3 == 2)
                chk($sformatf("rr_sum_c%0d", c), {32'd0, resp_sum},
                    ((c / 3) % 2 == 0) ? 64'd13 : 64'd7);
            tick();
        end

        // Backpressure: hold RESP for 5 cycles while requester 1 waits.
        do_reset();
        req_a = {32'd100, 32'd40};
        req_b = {32'd1, 32'd2};
        req_sub = 2'b00;
        req_valid = 2'b11;
        resp_ready = 2'b00;
        @(negedge clk);
        chk("bp_accept0", {62'd0, req_ready}, 64'd1);
        tick();
        req_valid = 2'b10;
        tick();
        resp_ready = 2'b10;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold_valid", {62'd0, resp_valid}, 64'd1);
            chk("bp_hold_sum", {32'd0, resp_sum}, 64'd42);
            chk("bp_no_ready", {62'd0, req_ready}, 64'd0);
            tick();
        end
        resp_ready = 2'b01;
        @(negedge clk);
        chk("bp_complete_valid", {62'd0, resp_valid}, 64'd1);
        tick();
        @(negedge clk);
        chk("bp_accept1", {62'd0, req_ready}, 64'd2);
        tick();
        req_valid = 2'b00;
        resp_ready = 2'b11;
        tick();
        @(negedge clk);
        chk("bp_resp1_sum", {32'd0, resp_sum}, 64'd101);
        tick();

        // Reset mid-EXEC discards the op and clears outputs at once.
        run_op(vecs[0]);
        req_a[0 +: W] = 32'd7;
        req_b[0 +: W] = 32'd9;
        req_sub = 2'b00;
        req_valid = 2'b01;
        @(negedge clk);
        chk("rx_accept", {62'd0, req_ready}, 64'd1);
        tick();
        req_valid = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rx_resp_valid", {62'd0, resp_valid}, 64'd0);
        chk("rx_sum", {32'd0, resp_sum}, 64'd0);
        chk("rx_ready", {62'd0, req_ready}, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rx_discarded", {62'd0, resp_valid}, 64'd0);
            tick();
        end
        // Requester 0 completed last before reset; rr must be back at 0.
        req_a = {32'd1, 32'd2};
        req_b = {32'd1, 32'd2};
        req_valid = 2'b11;
        @(negedge clk);
        chk("rx_rr_zero", {62'd0, req_ready}, 64'd1);
        tick();
        req_valid = 2'b00;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Shares one 32-bit add/subtract unit between two requesters. Each requester issues an operation (a, b, add/sub) over a valid/ready handshake. The block grants one requester at a time with round-robin priority, sequences the operation through the shared adder, and returns sum, carry-out and overflow over a per-requester valid/ready response handshake. It sits between the ALU-side datapath clients and the existing ripple-carry add/sub unit.

## Interface
- WIDTH, 32, operand/result width in bits
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-requester operation valid (bit i = requester i)
- req_ready  out  2  one-hot accept strobe; bit i high for exactly the cycle requester i's operation is captured
- req_a  in  2*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
- req_b  in  2*WIDTH  operand B, same packing as req_a
- req_sub  in  2  per-requester op select: 0 = A+B, 1 = A−B
- resp_valid  out  2  one-hot result valid for the granted requester
- resp_ready  in  2  per-requester result accept
- resp_sum  out  WIDTH  result, shared by both requesters, meaningful only while a resp_valid bit is set
- resp_cout  out  1  carry-out (for subtract: 1 = no borrow)
- resp_ovf  out  1  signed two's-complement overflow

## Operation
- FSM states:
  - IDLE: if any req_valid, pick grant g. Assert req_ready[g] combinationally. On the edge, latch req_a/b/sub of g plus g itself. Go to EXEC.
  - EXEC: latched operands drive the adder. On the edge, register sum/cout/ovf and go to RESP.
  - RESP: resp_valid[g]=1 with stable registered data. When resp_ready[g]=1, go to IDLE and set rr to the requester not equal to g.
- Arbitration:
  - Round-robin pointer rr (1 bit) is the priority holder.
  - One requester valid: it wins regardless of rr.
  - Both valid: rr wins.
  - rr updates only on response completion.
- Arithmetic:
  - Subtract is A + ~B + 1: the adder's cy_in = req_sub and B is XOR-inverted by req_sub.
  - cout = adder carry out of bit WIDTH−1.
  - ovf = (A[msb] == B'[msb]) && (sum[msb] != A[msb]), where B' is the possibly inverted B.
- Protocol rules:
  - A requester holds valid and operands stable until its req_ready.
  - req_ready is never asserted outside IDLE.
  - The non-granted requester waits and is not dropped.
  - resp_ready of the non-granted requester is ignored.
- Reset (asserted at any time, including mid-EXEC/RESP):
  - Outputs go to their reset values immediately and any in-flight operation is discarded.
  - Reset values: state=IDLE, rr=0, req_ready=0 (IDLE with no valid), resp_valid=0, resp_sum=0, resp_cout=0, resp_ovf=0.

## Timing
- Accept edge N (req_ready[g]=1 in cycle N). resp_valid[g] rises in cycle N+2.
- If resp_ready is held high, the response completes at the end of cycle N+2 and the next accept can happen in cycle N+3. Peak throughput is one operation per 3 cycles.
- Backpressure: RESP holds indefinitely. resp_sum/cout/ovf stay constant until completion.
- The adder path is combinational only within EXEC; no outputs are driven combinationally from the adder.
- The only combinational output path is req_valid → req_ready in IDLE.

## Structure
- Shared header/package holds:
  - WIDTH default
  - FSM state encodings: IDLE=2'd0, EXEC=2'd1, RESP=2'd2
  - requester count constant NREQ=2
- One sub-module: the existing N_bit_adder (32-bit add/sub with cy_in, answer, carry_out, overflow), instantiated once. Its overflow output may be used if it matches the rule above; otherwise compute ovf locally.
- The arbiter and FSM stay in addsub_arbiter; no separate arbiter module.

## Test plan
- Requester 0 sends a=1011, b=1027, sub=0. Expect resp_valid=2'b01 two cycles after accept, sum=2038, cout=0, ovf=0.
- Requester 1 sends a=1011, b=1027, sub=1. Expect resp_valid=2'b10, sum=32'hFFFF_FFF0, cout=0 (borrow), ovf=0.
- a=32'h7FFF_FFFF, b=1, add → sum=32'h8000_0000, ovf=1, cout=0. Then a=32'h8000_0000, b=1, sub → sum=32'h7FFF_FFFF, ovf=1, cout=1.
- Both requesters valid continuously from reset release. Grants alternate 0,1,0,1; each response arrives 3 cycles apart with resp_ready=1.
- resp_ready low for 5 cycles in RESP: resp_valid and data hold unchanged, req_ready stays 0, and the other pending requester is not accepted until completion.
- Pulse rst_n low during EXEC: resp_valid=0 and resp_sum=0 immediately; after release the FSM is in IDLE with rr=0 and the discarded operation never responds.
